// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared constants for the ID/EX stage: control-bundle bit positions,
// operand-mux select encodings and default widths.
package id_ex_fwd_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RA_W_DEF   = 5;
    localparam int CTRL_W_DEF = 8;
    localparam int SHAMT_W    = 5;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_SHIFT_SRC  = 4;
    localparam int CTRL_ALU_OP_LSB = 5;

    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,
        SEL_EXMEM = 2'b01,
        SEL_MEMWB = 2'b10,
        SEL_IMM   = 2'b11
    } fwd_sel_e;

    function automatic logic is_fwd(input fwd_sel_e s);
        return (s == SEL_EXMEM) || (s == SEL_MEMWB);
    endfunction

endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel_unit.sv
// Combinational forwarding-select for one EX operand: immediate override,
// then EX/MEM match, then MEM/WB match, else register-file data.
module id_ex_fwd_stage_fwd_sel_unit
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic            en,
    input  logic            imm_ovr,
    input  logic [RA_W-1:0] src_reg,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    output fwd_sel_e        sel
);

    logic exmem_hit;
    logic memwb_hit;

    // Register 0 is hardwired, so a write to it never produces a forward.
    assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_reg);
    assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_reg);

    always_comb begin
        sel = SEL_REG;
        if (en) begin
            if (imm_ovr) begin
                sel = SEL_IMM;
            end else if (exmem_hit) begin
                sel = SEL_EXMEM;
            end else if (memwb_hit) begin
                sel = SEL_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use stall detection and EX operand
// forwarding selects. Optional counters enabled by ID_EX_FWD_STATS_EN.
module id_ex_fwd_stage
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                id_valid_i,
    input  logic [RA_W-1:0]     id_rs_i,
    input  logic [RA_W-1:0]     id_rt_i,
    input  logic [RA_W-1:0]     id_rd_i,
    input  logic                id_uses_rs_i,
    input  logic                id_uses_rt_i,
    input  logic [DATA_W-1:0]   id_rs_data_i,
    input  logic [DATA_W-1:0]   id_rt_data_i,
    input  logic [DATA_W-1:0]   id_imm_i,
    input  logic [SHAMT_W-1:0]  id_shamt_i,
    input  logic [CTRL_W-1:0]   id_ctrl_i,
    input  logic                flush_i,
    input  logic                exmem_reg_write_i,
    input  logic [RA_W-1:0]     exmem_rd_i,
    input  logic                memwb_reg_write_i,
    input  logic [RA_W-1:0]     memwb_rd_i,
    output logic                stall_o,
    output logic                ex_valid_o,
    output logic [CTRL_W-1:0]   ex_ctrl_o,
    output logic [RA_W-1:0]     ex_rs_o,
    output logic [RA_W-1:0]     ex_rt_o,
    output logic [RA_W-1:0]     ex_rd_o,
    output logic [DATA_W-1:0]   ex_rs_data_o,
    output logic [DATA_W-1:0]   ex_rt_data_o,
    output logic [DATA_W-1:0]   ex_imm_o,
    output logic [DATA_W-1:0]   ex_shamt_o,
    output logic [1:0]          fwd_a_sel_o,
    output logic [1:0]          fwd_b_sel_o,
    output logic [1:0]          fwd_st_sel_o
`ifdef ID_EX_FWD_STATS_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         fwd_cnt_o
`endif
);

    logic               rs_dep;
    logic               rt_dep;
    logic [SHAMT_W-1:0] ex_shamt_q;
    fwd_sel_e           sel_a;
    fwd_sel_e           sel_b;
    fwd_sel_e           sel_st;

    // A load in EX cannot forward yet; a dependent ID instruction waits one
    // cycle and then picks the value up from MEM/WB.
    assign rs_dep  = id_uses_rs_i && (id_rs_i == ex_rd_o);
    assign rt_dep  = id_uses_rt_i && (id_rt_i == ex_rd_o);
    assign stall_o = ex_valid_o && ex_ctrl_o[CTRL_MEM_READ] && (ex_rd_o != '0)
                     && id_valid_i && (rs_dep || rt_dep);

    // ex_valid_o qualifies every ex_* field: while low, EX holds a bubble with
    // zero control, the address/data fields are stale and all selects are 00.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_valid_o   <= 1'b0;
            ex_ctrl_o    <= '0;
            ex_rs_o      <= '0;
            ex_rt_o      <= '0;
            ex_rd_o      <= '0;
            ex_rs_data_o <= '0;
            ex_rt_data_o <= '0;
            ex_imm_o     <= '0;
            ex_shamt_q   <= '0;
        end else if (flush_i || stall_o) begin
            ex_valid_o <= 1'b0;
            ex_ctrl_o  <= '0;
        end else begin
            ex_valid_o   <= id_valid_i;
            ex_ctrl_o    <= id_valid_i ? id_ctrl_i : '0;
            ex_rs_o      <= id_rs_i;
            ex_rt_o      <= id_rt_i;
            ex_rd_o      <= id_rd_i;
            ex_rs_data_o <= id_rs_data_i;
            ex_rt_data_o <= id_rt_data_i;
            ex_imm_o     <= id_imm_i;
            ex_shamt_q   <= id_shamt_i;
        end
    end

    assign ex_shamt_o = {{(DATA_W-SHAMT_W){1'b0}}, ex_shamt_q};

    id_ex_fwd_stage_fwd_sel_unit #(.RA_W(RA_W)) u_fwd_a (
        .en              (ex_valid_o),
        .imm_ovr         (ex_ctrl_o[CTRL_SHIFT_SRC]),
        .src_reg         (ex_rs_o),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_rd        (exmem_rd_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_rd        (memwb_rd_i),
        .sel             (sel_a)
    );

    id_ex_fwd_stage_fwd_sel_unit #(.RA_W(RA_W)) u_fwd_b (
        .en              (ex_valid_o),
        .imm_ovr         (ex_ctrl_o[CTRL_ALU_SRC]),
        .src_reg         (ex_rt_o),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_rd        (exmem_rd_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_rd        (memwb_rd_i),
        .sel             (sel_b)
    );

    // Store data always comes from rt, never from the immediate.
    id_ex_fwd_stage_fwd_sel_unit #(.RA_W(RA_W)) u_fwd_st (
        .en              (ex_valid_o && ex_ctrl_o[CTRL_MEM_WRITE]),
        .imm_ovr         (1'b0),
        .src_reg         (ex_rt_o),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_rd        (exmem_rd_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_rd        (memwb_rd_i),
        .sel             (sel_st)
    );

    assign fwd_a_sel_o  = sel_a;
    assign fwd_b_sel_o  = sel_b;
    assign fwd_st_sel_o = sel_st;

`ifdef ID_EX_FWD_STATS_EN
    logic fwd_any;
    assign fwd_any = is_fwd(sel_a) || is_fwd(sel_b) || is_fwd(sel_st);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (fwd_any && (fwd_cnt_o != '1)) begin
                fwd_cnt_o <= fwd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage: the driver pushes hand-computed
// expectations into a queue, the monitor pops and compares mid-cycle.
module tb_id_ex_fwd_stage;

    localparam int VW = 159;

    localparam logic [7:0] C_SUB  = 8'h41;
    localparam logic [7:0] C_ADD  = 8'h21;
    localparam logic [7:0] C_LW   = 8'h0B;
    localparam logic [7:0] C_SW   = 8'h0C;
    localparam logic [7:0] C_ADDI = 8'h09;
    localparam logic [7:0] C_SLL  = 8'h71;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic        id_uses_rs_i, id_uses_rt_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_shamt_i;
    logic [7:0]  id_ctrl_i;
    logic        flush_i;
    logic        exmem_reg_write_i;
    logic [4:0]  exmem_rd_i;
    logic        memwb_reg_write_i;
    logic [4:0]  memwb_rd_i;
    logic        stall_o;
    logic        ex_valid_o;
    logic [7:0]  ex_ctrl_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
    logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_shamt_o;
    logic [1:0]  fwd_a_sel_o, fwd_b_sel_o, fwd_st_sel_o;
`ifdef ID_EX_FWD_STATS_EN
    logic [31:0] stall_cnt_o, fwd_cnt_o;
`endif

    id_ex_fwd_stage dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .id_valid_i        (id_valid_i),
        .id_rs_i           (id_rs_i),
        .id_rt_i           (id_rt_i),
        .id_rd_i           (id_rd_i),
        .id_uses_rs_i      (id_uses_rs_i),
        .id_uses_rt_i      (id_uses_rt_i),
        .id_rs_data_i      (id_rs_data_i),
        .id_rt_data_i      (id_rt_data_i),
        .id_imm_i          (id_imm_i),
        .id_shamt_i        (id_shamt_i),
        .id_ctrl_i         (id_ctrl_i),
        .flush_i           (flush_i),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .stall_o           (stall_o),
        .ex_valid_o        (ex_valid_o),
        .ex_ctrl_o         (ex_ctrl_o),
        .ex_rs_o           (ex_rs_o),
        .ex_rt_o           (ex_rt_o),
        .ex_rd_o           (ex_rd_o),
        .ex_rs_data_o      (ex_rs_data_o),
        .ex_rt_data_o      (ex_rt_data_o),
        .ex_imm_o          (ex_imm_o),
        .ex_shamt_o        (ex_shamt_o),
        .fwd_a_sel_o       (fwd_a_sel_o),
        .fwd_b_sel_o       (fwd_b_sel_o),
        .fwd_st_sel_o      (fwd_st_sel_o)
`ifdef ID_EX_FWD_STATS_EN
        ,
        .stall_cnt_o       (stall_cnt_o),
        .fwd_cnt_o         (fwd_cnt_o)
`endif
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    initial begin
        #50000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    logic [VW-1:0] exp_q[$];
    string         name_q[$];

    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            logic [VW-1:0] exp_v;
            logic [VW-1:0] act_v;
            string         nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {stall_o, ex_valid_o, ex_ctrl_o, fwd_a_sel_o, fwd_b_sel_o, fwd_st_sel_o,
                     ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_shamt_o};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", nm, act_v, exp_v);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] sh, input logic [7:0] ctrl);
        id_valid_i   = v;
        id_rs_i      = rs;
        id_rt_i      = rt;
        id_rd_i      = rd;
        id_uses_rs_i = urs;
        id_uses_rt_i = urt;
        id_rs_data_i = rsd;
        id_rt_data_i = rtd;
        id_imm_i     = imm;
        id_shamt_i   = sh;
        id_ctrl_i    = ctrl;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd,
                           input logic mw, input logic [4:0] mrd);
        exmem_reg_write_i = ew;
        exmem_rd_i        = erd;
        memwb_reg_write_i = mw;
        memwb_rd_i        = mrd;
    endtask

    task automatic expect_out(input string nm, input logic st, input logic v,
                              input logic [7:0] ctrl, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [1:0] sst,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [31:0] imm, input logic [4:0] sh);
        exp_q.push_back({st, v, ctrl, sa, sb, sst, rs, rt, rd, rsd, rtd, imm, {27'd0, sh}});
        name_q.push_back(nm);
    endtask

    logic [31:0] r[16];
    logic [4:0]  sh;

    // Stimulus
    initial begin
        for (int i = 0; i < 16; i++) r[i] = $urandom_range(32'h7fff_ffff, 1);
        sh = 5'($urandom_range(31, 1));

        rst_i   = 1'b0;
        flush_i = 1'b0;
        set_fwd(0, 0, 0, 0);
        set_id(1, 3, 4, 6, 1, 1, r[0], r[1], r[2], 0, C_SUB);
        tick();
        tick();
        expect_out("reset", 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;

        tick();
        set_fwd(1, 3, 0, 0);
        set_id(1, 5, 9, 8, 1, 1, r[3], r[4], r[5], 0, C_ADD);
        expect_out("exmem_fwd_a", 0, 1, C_SUB, 2'b01, 2'b00, 2'b00, 3, 4, 6, r[0], r[1], r[2], 0);

        tick();
        set_fwd(1, 5, 1, 5);
        expect_out("exmem_priority", 0, 1, C_ADD, 2'b01, 2'b00, 2'b00, 5, 9, 8, r[3], r[4], r[5], 0);

        tick();
        set_fwd(0, 0, 1, 5);
        expect_out("memwb_only", 0, 1, C_ADD, 2'b10, 2'b00, 2'b00, 5, 9, 8, r[3], r[4], r[5], 0);

        tick();
        set_fwd(1, 0, 1, 0);
        set_id(1, 2, 7, 7, 1, 0, r[6], r[7], r[8], 0, C_LW);
        expect_out("rd0_no_fwd", 0, 1, C_ADD, 2'b00, 2'b00, 2'b00, 5, 9, 8, r[3], r[4], r[5], 0);

        tick();
        set_fwd(0, 0, 0, 0);
        set_id(1, 7, 11, 10, 1, 1, r[9], r[10], r[11], 0, C_ADD);
        expect_out("load_use_stall", 1, 1, C_LW, 2'b00, 2'b11, 2'b00, 2, 7, 7, r[6], r[7], r[8], 0);

        tick();
        set_fwd(1, 7, 0, 0);
        expect_out("stall_bubble", 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2, 7, 7, r[6], r[7], r[8], 0);

        tick();
        set_fwd(0, 0, 1, 7);
        set_id(1, 1, 12, 12, 1, 0, r[12], r[13], r[14], 0, C_LW);
        expect_out("memwb_after_stall", 0, 1, C_ADD, 2'b10, 2'b00, 2'b00, 7, 11, 10, r[9], r[10], r[11], 0);

        tick();
        set_fwd(0, 0, 0, 0);
        set_id(1, 12, 5, 20, 1, 0, r[15], r[3], r[6], 0, C_ADD);
        flush_i = 1'b1;
        expect_out("flush_with_stall", 1, 1, C_LW, 2'b00, 2'b11, 2'b00, 1, 12, 12, r[12], r[13], r[14], 0);

        tick();
        flush_i = 1'b0;
        set_id(1, 14, 13, 13, 1, 0, r[2], r[4], r[7], 0, C_ADDI);
        expect_out("single_bubble", 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 1, 12, 12, r[12], r[13], r[14], 0);

        tick();
        set_fwd(1, 13, 0, 0);
        set_id(1, 15, 13, 0, 1, 1, r[5], r[8], r[9], 0, C_SW);
        expect_out("alu_src_imm_b", 0, 1, C_ADDI, 2'b00, 2'b11, 2'b00, 14, 13, 13, r[2], r[4], r[7], 0);

        tick();
        set_id(1, 3, 4, 6, 1, 1, r[10], r[11], r[12], 0, C_SUB);
        flush_i = 1'b1;
        expect_out("store_fwd", 0, 1, C_SW, 2'b00, 2'b11, 2'b01, 15, 13, 0, r[5], r[8], r[9], 0);

        tick();
        flush_i = 1'b0;
        set_id(1, 0, 17, 16, 0, 1, r[13], r[14], r[15], sh, C_SLL);
        expect_out("flush_only", 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 15, 13, 0, r[5], r[8], r[9], 0);

        tick();
        set_fwd(1, 0, 1, 17);
        set_id(0, 21, 22, 23, 1, 1, r[0], r[1], r[2], 5'd31, 8'hFF);
        expect_out("shamt_sel", 0, 1, C_SLL, 2'b11, 2'b10, 2'b00, 0, 17, 16, r[13], r[14], r[15], sh);

        tick();
        set_fwd(0, 0, 0, 0);
        set_id(1, 3, 0, 0, 1, 0, r[3], r[4], r[5], 0, C_LW);
        expect_out("id_invalid", 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 21, 22, 23, r[0], r[1], r[2], 5'd31);

        tick();
        set_id(1, 0, 0, 9, 1, 1, r[6], r[7], r[8], 0, C_ADD);
        expect_out("load_r0_no_stall", 0, 1, C_LW, 2'b00, 2'b11, 2'b00, 3, 0, 0, r[3], r[4], r[5], 0);

        tick();
        tick();
        tick();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the 5-stage pipelined CPU.
- Adds load-use hazard detection and forwarding-select generation.
- Drives the 2-bit select inputs of the EX-stage 4-to-1 operand muxes (ALU A, ALU B, store data).
- Sits between the decoder/register file and the EX-stage muxes; produces the pipeline stall request for PC and IF/ID.

Parameters:
- DATA_W, 32, datapath width.
- RA_W, 5, register address width.
- CTRL_W, 8, control bundle width. Bits: [0] reg_write, [1] mem_read, [2] mem_write, [3] alu_src (B = immediate), [4] shift_src (A = shamt), [7:5] alu_op.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i, id_rt_i, id_rd_i  in  RA_W each  source and destination registers (id_rd_i is already the final write destination).
- id_uses_rs_i, id_uses_rt_i  in  1 each  source operand is actually read.
- id_rs_data_i, id_rt_data_i, id_imm_i  in  DATA_W each  register file read data; sign-extended immediate.
- id_shamt_i  in  5  shift amount.
- id_ctrl_i  in  CTRL_W  decoded control.
- flush_i  in  1  kill the instruction entering EX (taken branch/jump).
- exmem_reg_write_i  in  1  EX/MEM instruction writes a register.
- exmem_rd_i  in  RA_W  EX/MEM destination register.
- memwb_reg_write_i  in  1  MEM/WB instruction writes a register.
- memwb_rd_i  in  RA_W  MEM/WB destination register.
- stall_o  out  1  hold PC and IF/ID; combinational.
- ex_valid_o  out  1  EX holds a real instruction.
- ex_ctrl_o  out  CTRL_W  registered control.
- ex_rs_o, ex_rt_o, ex_rd_o  out  RA_W each  registered register addresses.
- ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DATA_W each  registered operands.
- ex_shamt_o  out  DATA_W  shamt zero-extended to DATA_W.
- fwd_a_sel_o, fwd_b_sel_o, fwd_st_sel_o  out  2 each  mux selects; combinational from registered state.

Behaviour:
- Reset (rst_i=0 at a clock edge): all registered outputs go to 0 and ex_valid_o=0. Consequently stall_o=0 and all selects are 00.
- Latency: one clock edge from ID inputs to ex_* outputs.
- stall_o = ex_valid_o & ex_ctrl_o[1] & (ex_rd_o!=0) & id_valid_i & ((id_uses_rs_i & id_rs_i==ex_rd_o) | (id_uses_rt_i & id_rt_i==ex_rd_o)).
- Register update on each clock edge (reset not active):
  - If flush_i=1 or stall_o=1: insert a bubble. ex_valid_o=0 and ex_ctrl_o=0; data/address registers are don't-care and are held.
  - Otherwise: latch all id_* fields. ex_valid_o=id_valid_i; ex_ctrl_o is forced to 0 when id_valid_i=0.
- Flush and stall in the same cycle produce a single bubble. stall_o still asserts so that IF/ID holds.
- A stall lasts exactly one cycle per load: after the bubble, the load moves to EX/MEM, mem_read in EX clears, and the dependency is served by forwarding from MEM/WB.
- Match definitions:
  - EX/MEM match on register r: exmem_reg_write_i & exmem_rd_i!=0 & exmem_rd_i==r.
  - MEM/WB match: same form using the memwb_* inputs.
  - Register 0 is never forwarded.
- fwd_a_sel_o: 11 if ex_ctrl_o[4]; else 01 on EX/MEM match of ex_rs_o; else 10 on MEM/WB match; else 00.
- fwd_b_sel_o: 11 if ex_ctrl_o[3]; else the same priority on ex_rt_o.
- fwd_st_sel_o: same priority on ex_rt_o, never 11; evaluated only when ex_ctrl_o[2]=1, otherwise 00.
- EX/MEM always wins over MEM/WB when both match.
- All selects are 00 while ex_valid_o=0.
- Mux data mapping: 00 = register data, 01 = EX/MEM ALU result, 10 = MEM/WB write-back data, 11 = immediate or shamt.

Optional Feature:
- Macro: ID_EX_FWD_STATS_EN.
- When defined, adds outputs stall_cnt_o and fwd_cnt_o (32 bits each), saturating at all-ones and cleared by reset:
  - stall_cnt_o increments on every cycle with stall_o=1.
  - fwd_cnt_o increments on every cycle where any select is 01 or 10.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Shared package: CTRL bit index constants, select encodings (SEL_REG=00, SEL_EXMEM=01, SEL_MEMWB=10, SEL_IMM=11), and the DATA_W/RA_W defaults.
- One sub-module, fwd_sel_unit: purely combinational match/priority logic. Instantiated three times (A, B, store) with an imm-override input.

Test Plan:
- Reset held 2 cycles with id_valid_i=1 -> ex_valid_o=0, ex_ctrl_o=0, all selects 00, stall_o=0.
- add $3 in EX/MEM (exmem_rd_i=3, reg_write=1), EX holds sub using $3,$4 -> fwd_a_sel_o=01, fwd_b_sel_o=00.
- EX/MEM and MEM/WB both writing $5, EX reads $5 as rs -> fwd_a_sel_o=01 (priority). With exmem_rd_i=0 and memwb_rd_i=0 -> 00.
- lw $7 in EX, ID add uses $7 -> stall_o=1 for one cycle and bubble enters EX (ex_valid_o=0). Next cycle with memwb_rd_i=7 -> fwd_a_sel_o=10.
- flush_i=1 together with a load-use stall -> single bubble, ex_ctrl_o=0, stall_o=1.
- addi with alu_src=1 and EX/MEM match on rt -> fwd_b_sel_o=11. A sw with an rt match -> fwd_st_sel_o=01.
